mips_control_decode: RTL and testbench

MIPS_CONTROL_DECODE -- requirements
Module: mips_control_decode

---
 rtl/mips_control_decode.sv | 215 +++++++++++++++++++++
 tb/tb_mips_control_decode.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_control_decode.sv
// MIPS main control and ALU control decoder with a registered output stage.
// The opcode, funct and immediate fields of one instruction word are decoded
// combinationally and captured together on a rising clock edge when en is high.
module mips_control_decode (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] instruction,
    output logic        RegWrite,
    output logic        ALUSrc,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        Branch,
    output logic        BranchNotEq,
    output logic        Jump,
    output logic        Unsigned,
    output logic [3:0]  ALUop,
    output logic [2:0]  aluCtr,
    output logic [31:0] extended
);

    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic [15:0] w_imm;

    logic        w_regWrite;
    logic        w_aluSrc;
    logic        w_regDst;
    logic        w_memtoReg;
    logic        w_memRead;
    logic        w_memWrite;
    logic        w_branch;
    logic        w_branchNotEq;
    logic        w_jump;
    logic        w_unsigned;
    logic [3:0]  w_aluOp;
    logic [2:0]  w_aluCtr;
    logic [31:0] w_extended;

    logic        r_regWrite;
    logic        r_aluSrc;
    logic        r_regDst;
    logic        r_memtoReg;
    logic        r_memRead;
    logic        r_memWrite;
    logic        r_branch;
    logic        r_branchNotEq;
    logic        r_jump;
    logic        r_unsigned;
    logic [3:0]  r_aluOp;
    logic [2:0]  r_aluCtr;
    logic [31:0] r_extended;

    assign w_opcode = instruction[31:26];
    assign w_funct  = instruction[5:0];
    assign w_imm    = instruction[15:0];

    // Main control: opcode to datapath control signals and ALU operation class.
    always_comb begin
        w_regWrite    = 1'b0;
        w_aluSrc      = 1'b0;
        w_regDst      = 1'b0;
        w_memtoReg    = 1'b0;
        w_memRead     = 1'b0;
        w_memWrite    = 1'b0;
        w_branch      = 1'b0;
        w_branchNotEq = 1'b0;
        w_jump        = 1'b0;
        w_unsigned    = 1'b0;
        w_aluOp       = 4'b0000;
        case (w_opcode)
            6'b000000: begin
                w_regWrite = 1'b1;
                w_regDst   = 1'b1;
                w_aluOp    = 4'b0010;
            end
            6'b100011: begin
                w_regWrite = 1'b1;
                w_aluSrc   = 1'b1;
                w_memtoReg = 1'b1;
                w_memRead  = 1'b1;
            end
            6'b101011: begin
                w_aluSrc   = 1'b1;
                w_memWrite = 1'b1;
            end
            6'b000100: begin
                w_branch = 1'b1;
                w_aluOp  = 4'b0001;
            end
            6'b000101: begin
                w_branchNotEq = 1'b1;
                w_aluOp       = 4'b0001;
            end
            6'b000010: begin
                w_jump = 1'b1;
            end
            6'b001000, 6'b001001: begin
                w_regWrite = 1'b1;
                w_aluSrc   = 1'b1;
            end
            6'b001100: begin
                w_regWrite = 1'b1;
                w_aluSrc   = 1'b1;
                w_unsigned = 1'b1;
                w_aluOp    = 4'b0011;
            end
            6'b001101: begin
                w_regWrite = 1'b1;
                w_aluSrc   = 1'b1;
                w_unsigned = 1'b1;
                w_aluOp    = 4'b0100;
            end
            6'b001110: begin
                w_regWrite = 1'b1;
                w_aluSrc   = 1'b1;
                w_unsigned = 1'b1;
                w_aluOp    = 4'b0110;
            end
            6'b001010, 6'b001011: begin
                w_regWrite = 1'b1;
                w_aluSrc   = 1'b1;
                w_aluOp    = 4'b0101;
            end
            default: begin
                w_aluOp = 4'b0000;
            end
        endcase
    end

    // ALU control: class code to ALU operation, consulting funct only for R-type.
    always_comb begin
        w_aluCtr = 3'b010;
        case (w_aluOp)
            4'b0000: w_aluCtr = 3'b010;
            4'b0001: w_aluCtr = 3'b110;
            4'b0011: w_aluCtr = 3'b000;
            4'b0100: w_aluCtr = 3'b001;
            4'b0101: w_aluCtr = 3'b111;
            4'b0110: w_aluCtr = 3'b011;
            4'b0010: begin
                case (w_funct)
                    6'b100000, 6'b100001: w_aluCtr = 3'b010;
                    6'b100010, 6'b100011: w_aluCtr = 3'b110;
                    6'b100100:            w_aluCtr = 3'b000;
                    6'b100101:            w_aluCtr = 3'b001;
                    6'b100110:            w_aluCtr = 3'b011;
                    6'b101010, 6'b101011: w_aluCtr = 3'b111;
                    6'b000000:            w_aluCtr = 3'b100;
                    6'b000010:            w_aluCtr = 3'b101;
                    default:              w_aluCtr = 3'b010;
                endcase
            end
            default: w_aluCtr = 3'b010;
        endcase
    end

    // Logical immediates are zero-extended; everything else is sign-extended.
    always_comb begin
        w_extended = {{16{w_imm[15]}}, w_imm};
        if (w_unsigned) begin
            w_extended = {16'h0000, w_imm};
        end
    end

    // Capture one instruction's full decode on an enabled edge; reset clears it all.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_regWrite    <= 1'b0;
            r_aluSrc      <= 1'b0;
            r_regDst      <= 1'b0;
            r_memtoReg    <= 1'b0;
            r_memRead     <= 1'b0;
            r_memWrite    <= 1'b0;
            r_branch      <= 1'b0;
            r_branchNotEq <= 1'b0;
            r_jump        <= 1'b0;
            r_unsigned    <= 1'b0;
            r_aluOp       <= 4'b0000;
            r_aluCtr      <= 3'b000;
            r_extended    <= 32'h0000_0000;
        end else if (en) begin
            r_regWrite    <= w_regWrite;
            r_aluSrc      <= w_aluSrc;
            r_regDst      <= w_regDst;
            r_memtoReg    <= w_memtoReg;
            r_memRead     <= w_memRead;
            r_memWrite    <= w_memWrite;
            r_branch      <= w_branch;
            r_branchNotEq <= w_branchNotEq;
            r_jump        <= w_jump;
            r_unsigned    <= w_unsigned;
            r_aluOp       <= w_aluOp;
            r_aluCtr      <= w_aluCtr;
            r_extended    <= w_extended;
        end
    end

    assign RegWrite    = r_regWrite;
    assign ALUSrc      = r_aluSrc;
    assign RegDst      = r_regDst;
    assign MemtoReg    = r_memtoReg;
    assign MemRead     = r_memRead;
    assign MemWrite    = r_memWrite;
    assign Branch      = r_branch;
    assign BranchNotEq = r_branchNotEq;
    assign Jump        = r_jump;
    assign Unsigned    = r_unsigned;
    assign ALUop       = r_aluOp;
    assign aluCtr      = r_aluCtr;
    assign extended    = r_extended;

endmodule

// File: tb/tb_mips_control_decode.sv
// Testbench for mips_control_decode: directed cases plus randomized instructions
// checked against a behavioural model of the MIPS control rules.
module tb_mips_control_decode;

    typedef struct packed {
        logic        regWrite;
        logic        aluSrc;
        logic        regDst;
        logic        memtoReg;
        logic        memRead;
        logic        memWrite;
        logic        branch;
        logic        branchNotEq;
        logic        jump;
        logic        uns;
        logic [3:0]  aluOp;
        logic [2:0]  aluCtr;
        logic [31:0] ext;
    } decodeT;

    logic        clock;
    logic        rst_n;
    logic        en;
    logic [31:0] instruction;
    logic        RegWrite, ALUSrc, RegDst, MemtoReg, MemRead, MemWrite;
    logic        Branch, BranchNotEq, Jump, Unsigned;
    logic [3:0]  ALUop;
    logic [2:0]  aluCtr;
    logic [31:0] extended;

    decodeT obs;
    decodeT expected;
    int     checks;
    int     errors;

    localparam logic [5:0] KNOWN_OPS [14] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08,
                                              6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0B, 6'h3F};

    mips_control_decode dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .en          (en),
        .instruction (instruction),
        .RegWrite    (RegWrite),
        .ALUSrc      (ALUSrc),
        .RegDst      (RegDst),
        .MemtoReg    (MemtoReg),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .Branch      (Branch),
        .BranchNotEq (BranchNotEq),
        .Jump        (Jump),
        .Unsigned    (Unsigned),
        .ALUop       (ALUop),
        .aluCtr      (aluCtr),
        .extended    (extended)
    );

    assign obs = '{RegWrite, ALUSrc, RegDst, MemtoReg, MemRead, MemWrite, Branch,
                   BranchNotEq, Jump, Unsigned, ALUop, aluCtr, extended};

    // Free-running clock, 10 time units per period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model: what each instruction means, expressed per operation.
    function automatic decodeT model(input logic [31:0] ins);
        decodeT e;
        logic [5:0] op;
        logic [5:0] fn;
        int         imm;
        int         value;
        e   = '0;
        op  = ins[31:26];
        fn  = ins[5:0];
        imm = int'(ins[15:0]);
        e.aluCtr = 3'd2;
        case (op)
            6'h00: begin
                e.regWrite = 1; e.regDst = 1; e.aluOp = 4'd2;
                case (fn)
                    6'h22, 6'h23: e.aluCtr = 3'd6;
                    6'h24:        e.aluCtr = 3'd0;
                    6'h25:        e.aluCtr = 3'd1;
                    6'h26:        e.aluCtr = 3'd3;
                    6'h2A, 6'h2B: e.aluCtr = 3'd7;
                    6'h00:        e.aluCtr = 3'd4;
                    6'h02:        e.aluCtr = 3'd5;
                    default:      e.aluCtr = 3'd2;
                endcase
            end
            6'h23: begin e.regWrite = 1; e.aluSrc = 1; e.memtoReg = 1; e.memRead = 1; end
            6'h2B: begin e.aluSrc = 1; e.memWrite = 1; end
            6'h04: begin e.branch = 1; e.aluOp = 4'd1; e.aluCtr = 3'd6; end
            6'h05: begin e.branchNotEq = 1; e.aluOp = 4'd1; e.aluCtr = 3'd6; end
            6'h02: e.jump = 1;
            6'h08, 6'h09: begin e.regWrite = 1; e.aluSrc = 1; end
            6'h0C: begin e.regWrite = 1; e.aluSrc = 1; e.uns = 1; e.aluOp = 4'd3; e.aluCtr = 3'd0; end
            6'h0D: begin e.regWrite = 1; e.aluSrc = 1; e.uns = 1; e.aluOp = 4'd4; e.aluCtr = 3'd1; end
            6'h0E: begin e.regWrite = 1; e.aluSrc = 1; e.uns = 1; e.aluOp = 4'd6; e.aluCtr = 3'd3; end
            6'h0A, 6'h0B: begin e.regWrite = 1; e.aluSrc = 1; e.aluOp = 4'd5; e.aluCtr = 3'd7; end
            default: e.aluCtr = 3'd2;
        endcase
        value = (!e.uns && imm >= 32768) ? imm - 65536 : imm;
        e.ext = 32'(value);
        return e;
    endfunction

    // Compare one observed value against its expectation and tally the result.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] want);
        checks++;
        if (observed !== want) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, want);
        end
    endtask

    // Drive one instruction, clock it in, and track what the outputs should become.
    task automatic applyStimulus(input logic [31:0] ins, input logic load);
        instruction = ins;
        en          = load;
        @(posedge clock);
        #1;
        if (load && rst_n) expected = model(ins);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        en          = 1'b1;
        instruction = 32'h8FA8_FFFC;
        expected    = '0;

        // Reset holds everything at zero even across enabled edges.
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_state", 64'(obs), 64'(decodeT'('0)));
        rst_n = 1'b1;

        // lw
        applyStimulus(32'h8FA8_FFFC, 1'b1);
        checkOutput("lw_ctrl", {RegWrite, ALUSrc, MemtoReg, MemRead, Unsigned}, 5'b11110);
        checkOutput("lw_aluop", ALUop, 4'b0000);
        checkOutput("lw_aluctr", aluCtr, 3'b010);
        checkOutput("lw_ext", extended, 32'hFFFF_FFFC);
        checkOutput("lw_all", 64'(obs), 64'(expected));

        // Asynchronous reset between edges, then reload after release.
        #2 rst_n = 1'b0;
        #1 checkOutput("async_reset", 64'(obs), 64'd0);
        expected = '0;
        applyStimulus(32'h8FA8_FFFC, 1'b1);
        checkOutput("reset_ignores_edge", 64'(obs), 64'd0);
        rst_n = 1'b1;
        applyStimulus(32'h8FA8_FFFC, 1'b1);
        checkOutput("reload_after_reset", 64'(obs), 64'(model(32'h8FA8_FFFC)));

        // andi then addi with the same immediate.
        applyStimulus(32'h3108_8000, 1'b1);
        checkOutput("andi_uns", Unsigned, 1'b1);
        checkOutput("andi_aluop", ALUop, 4'b0011);
        checkOutput("andi_aluctr", aluCtr, 3'b000);
        checkOutput("andi_ext", extended, 32'h0000_8000);
        applyStimulus(32'h2108_8000, 1'b1);
        checkOutput("addi_ext", extended, 32'hFFFF_8000);
        checkOutput("addi_aluctr", aluCtr, 3'b010);

        // R-type funct decodes.
        applyStimulus(32'h0128_5022, 1'b1);
        checkOutput("sub_aluctr", aluCtr, 3'b110);
        checkOutput("sub_rd", {RegDst, RegWrite}, 2'b11);
        applyStimulus(32'h0128_502A, 1'b1);
        checkOutput("slt_aluctr", aluCtr, 3'b111);
        applyStimulus(32'h0009_5100, 1'b1);
        checkOutput("sll_aluctr", aluCtr, 3'b100);
        applyStimulus(32'h0128_503F, 1'b1);
        checkOutput("badfunct_aluctr", aluCtr, 3'b010);
        checkOutput("badfunct_rd", {RegDst, RegWrite}, 2'b11);

        // Branches and jump.
        applyStimulus(32'h1109_FFFE, 1'b1);
        checkOutput("beq_branch", {Branch, BranchNotEq}, 2'b10);
        checkOutput("beq_aluctr", aluCtr, 3'b110);
        checkOutput("beq_ext", extended, 32'hFFFF_FFFE);
        applyStimulus(32'h1509_FFFE, 1'b1);
        checkOutput("bne_branch", {Branch, BranchNotEq}, 2'b01);
        applyStimulus(32'h0800_0010, 1'b1);
        checkOutput("j_ctrl", {Jump, RegWrite}, 2'b10);
        checkOutput("j_ext", extended, 32'h0000_0010);

        // Undefined opcode, then en=0 holds.
        applyStimulus(32'hFC00_0000, 1'b1);
        checkOutput("undef_ctrl", {RegWrite, ALUSrc, RegDst, MemtoReg, MemRead, MemWrite,
                                   Branch, BranchNotEq, Jump, Unsigned, ALUop}, 14'd0);
        checkOutput("undef_aluctr", aluCtr, 3'b010);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'h8FA8_FFFC, 1'b0);
            checkOutput("hold_en0", 64'(obs), 64'(model(32'hFC00_0000)));
        end

        // Randomized instructions with random enable and occasional async reset.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ins;
            ins = $urandom;
            if ($urandom_range(0, 9) < 8) ins[31:26] = KNOWN_OPS[$urandom_range(0, 13)];
            applyStimulus(ins, ($urandom_range(0, 3) != 0));
            checkOutput("random", 64'(obs), 64'(expected));
            if ($urandom_range(0, 24) == 0) begin
                #2 rst_n = 1'b0;
                #1 checkOutput("random_reset", 64'(obs), 64'd0);
                expected = '0;
                rst_n = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
